// File: rtl/axi_ar_burst_splitter.sv
// axi_ar_burst_splitter
//
// Splits each upstream AXI read burst into downstream sub-bursts of at most MAX_BEATS beats.
// R data passes straight through. Every intermediate rlast is masked, so the upstream side sees
// exactly one last beat per original request.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   s_ar_*              upstream read address channel (slave side)
//   m_ar_*              downstream sub-burst address channel (master side, to DRAM)
//   m_r_*               downstream read data channel from DRAM
//   s_r_*               upstream read data channel
//   busy                a split is in progress or requests are still outstanding
//   err                 sticky; an R beat arrived while nothing was outstanding
//
// DRAM must return sub-bursts in the order they were issued. No reordering is done here.
module axi_ar_burst_splitter #(
    parameter int unsigned ADDR_BITS            = 16,
    parameter int unsigned BURST_LEN_WIDTH      = 8,
    parameter int unsigned TID_WIDTH            = 8,
    parameter int unsigned LOG_BLOCK_DATA_BYTES = 0,
    parameter int unsigned MAX_BEATS            = 4,
    parameter int unsigned LOG_TRACK_DEPTH      = 2
) (
    input  logic                                  clk,
    input  logic                                  rst,

    input  logic                                  s_ar_valid,
    output logic                                  s_ar_ready,
    input  logic [ADDR_BITS-1:0]                  s_ar_addr,
    input  logic [BURST_LEN_WIDTH-1:0]            s_ar_len,
    input  logic [TID_WIDTH-1:0]                  s_ar_id,

    output logic                                  m_ar_valid,
    input  logic                                  m_ar_ready,
    output logic [ADDR_BITS-1:0]                  m_ar_addr,
    output logic [BURST_LEN_WIDTH-1:0]            m_ar_len,
    output logic [TID_WIDTH-1:0]                  m_ar_id,

    input  logic                                  m_r_valid,
    output logic                                  m_r_ready,
    input  logic [(8<<LOG_BLOCK_DATA_BYTES)-1:0]  m_r_data,
    input  logic [TID_WIDTH-1:0]                  m_r_id,
    input  logic                                  m_r_last,

    output logic                                  s_r_valid,
    input  logic                                  s_r_ready,
    output logic [(8<<LOG_BLOCK_DATA_BYTES)-1:0]  s_r_data,
    output logic [TID_WIDTH-1:0]                  s_r_id,
    output logic                                  s_r_last,

    output logic                                  busy,
    output logic                                  err
);

    // Beat counts (rem, chunk counts) need one bit more than the len field.
    localparam int unsigned LenW       = BURST_LEN_WIDTH + 1;
    localparam int unsigned TrackDepth = 1 << LOG_TRACK_DEPTH;
    localparam int unsigned LogMax     = $clog2(MAX_BEATS);
    localparam logic [LenW-1:0] MaxBeatsW = LenW'(MAX_BEATS);

    typedef enum logic [0:0] {StIdle, StSplit} state_e;

    state_e                     state_q;
    logic [ADDR_BITS-1:0]       addr_q;
    logic [TID_WIDTH-1:0]       id_q;
    logic [LenW-1:0]            rem_q;
    logic [LenW-1:0]            chunk_cnt_q;
    logic                       err_q;

    // Tracking FIFO: number of sub-bursts per outstanding original request.
    logic [LenW-1:0]            track_mem_q [TrackDepth];
    logic [LOG_TRACK_DEPTH-1:0] wr_ptr_q;
    logic [LOG_TRACK_DEPTH-1:0] rd_ptr_q;
    logic [LOG_TRACK_DEPTH:0]   count_q;

    logic                       track_full;
    logic                       track_empty;
    logic [LenW-1:0]            chunk_c;
    logic [LenW:0]              nchunks_sum;
    logic [LenW-1:0]            nchunks_c;
    logic [LenW-1:0]            head_nchunks;
    logic                       final_chunk;
    logic                       ar_in_hs;
    logic                       ar_out_hs;
    logic                       r_xfer;
    logic                       push;
    logic                       pop;

    assign track_full  = (count_q == (LOG_TRACK_DEPTH+1)'(TrackDepth));
    assign track_empty = (count_q == '0);

    // Ready depends on registered state only; no path from m_ar_ready.
    assign s_ar_ready = !rst && (state_q == StIdle) && !track_full;
    assign m_ar_valid = !rst && (state_q == StSplit);
    assign busy       = !rst && ((state_q == StSplit) || !track_empty);
    assign err        = err_q;

    assign chunk_c   = (rem_q > MaxBeatsW) ? MaxBeatsW : rem_q;
    assign m_ar_addr = addr_q;
    assign m_ar_len  = BURST_LEN_WIDTH'(chunk_c - LenW'(1));
    assign m_ar_id   = id_q;

    // ceil((len+1)/MAX_BEATS) == floor((len+MAX_BEATS)/MAX_BEATS)
    assign nchunks_sum = {2'b00, s_ar_len} + (LenW+1)'(MAX_BEATS);
    assign nchunks_c   = LenW'(nchunks_sum >> LogMax);

    assign ar_in_hs  = s_ar_valid && s_ar_ready;
    assign ar_out_hs = m_ar_valid && m_ar_ready;

    // R channel is a pure passthrough except for last masking.
    assign s_r_valid    = m_r_valid;
    assign m_r_ready    = s_r_ready;
    assign s_r_data     = m_r_data;
    assign s_r_id       = m_r_id;
    assign head_nchunks = track_mem_q[rd_ptr_q];
    assign final_chunk  = !track_empty && (chunk_cnt_q == head_nchunks - LenW'(1));
    assign s_r_last     = m_r_last && final_chunk;

    assign r_xfer = m_r_valid && s_r_ready;
    assign push   = ar_in_hs;
    assign pop    = r_xfer && m_r_last && final_chunk;

    always_ff @(posedge clk) begin
        if (push) begin
            track_mem_q[wr_ptr_q] <= nchunks_c;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            id_q        <= '0;
            rem_q       <= '0;
            chunk_cnt_q <= '0;
            err_q       <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (ar_in_hs) begin
                        addr_q  <= s_ar_addr;
                        id_q    <= s_ar_id;
                        rem_q   <= {1'b0, s_ar_len} + LenW'(1);
                        state_q <= StSplit;
                    end
                end
                StSplit: begin
                    if (ar_out_hs) begin
                        // Address wraps modulo 2^ADDR_BITS by truncation.
                        addr_q <= addr_q + (ADDR_BITS'(chunk_c) << LOG_BLOCK_DATA_BYTES);
                        rem_q  <= rem_q - chunk_c;
                        if (rem_q == chunk_c) begin
                            state_q <= StIdle;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase

            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (!push && pop) begin
                count_q <= count_q - 1'b1;
            end

            if (r_xfer && m_r_last && !track_empty) begin
                chunk_cnt_q <= final_chunk ? '0 : chunk_cnt_q + LenW'(1);
            end

            if (m_r_valid && track_empty) begin
                err_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_axi_ar_burst_splitter.sv
// Self-checking bench for axi_ar_burst_splitter. Expected AR sub-bursts and R beats are queued
// by the stimulus; a monitor pops and compares on every downstream AR and upstream R handshake.
module tb_axi_ar_burst_splitter;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_ar_valid;
    logic        s_ar_ready;
    logic [15:0] s_ar_addr;
    logic [7:0]  s_ar_len;
    logic [7:0]  s_ar_id;
    logic        m_ar_valid;
    logic        m_ar_ready;
    logic [15:0] m_ar_addr;
    logic [7:0]  m_ar_len;
    logic [7:0]  m_ar_id;
    logic        m_r_valid;
    logic        m_r_ready;
    logic [7:0]  m_r_data;
    logic [7:0]  m_r_id;
    logic        m_r_last;
    logic        s_r_valid;
    logic        s_r_ready;
    logic [7:0]  s_r_data;
    logic [7:0]  s_r_id;
    logic        s_r_last;
    logic        busy;
    logic        err;

    always #5 clk = ~clk;

    axi_ar_burst_splitter dut (
        .clk        (clk),
        .rst        (rst),
        .s_ar_valid (s_ar_valid),
        .s_ar_ready (s_ar_ready),
        .s_ar_addr  (s_ar_addr),
        .s_ar_len   (s_ar_len),
        .s_ar_id    (s_ar_id),
        .m_ar_valid (m_ar_valid),
        .m_ar_ready (m_ar_ready),
        .m_ar_addr  (m_ar_addr),
        .m_ar_len   (m_ar_len),
        .m_ar_id    (m_ar_id),
        .m_r_valid  (m_r_valid),
        .m_r_ready  (m_r_ready),
        .m_r_data   (m_r_data),
        .m_r_id     (m_r_id),
        .m_r_last   (m_r_last),
        .s_r_valid  (s_r_valid),
        .s_r_ready  (s_r_ready),
        .s_r_data   (s_r_data),
        .s_r_id     (s_r_id),
        .s_r_last   (s_r_last),
        .busy       (busy),
        .err        (err)
    );

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  len;
        logic [7:0]  id;
    } ar_t;

    typedef struct packed {
        logic [7:0] data;
        logic [7:0] id;
        logic       last;
    } r_t;

    ar_t ar_q[$];
    r_t  r_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor.
    ar_t ar_e;
    r_t  r_e;
    always @(negedge clk) begin
        if (m_ar_valid && m_ar_ready) begin
            if (ar_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL ar_unexpected: got addr 0x%0h len %0d, expected none", m_ar_addr,
                         m_ar_len);
            end else begin
                ar_e = ar_q.pop_front();
                chk("ar_addr", 32'(m_ar_addr), 32'(ar_e.addr));
                chk("ar_len", 32'(m_ar_len), 32'(ar_e.len));
                chk("ar_id", 32'(m_ar_id), 32'(ar_e.id));
            end
        end
        if (s_r_valid && s_r_ready) begin
            if (r_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL r_unexpected: got data 0x%0h, expected none", s_r_data);
            end else begin
                r_e = r_q.pop_front();
                chk("r_data", 32'(s_r_data), 32'(r_e.data));
                chk("r_id", 32'(s_r_id), 32'(r_e.id));
                chk("r_last", 32'(s_r_last), 32'(r_e.last));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_ar(input logic [15:0] a, input logic [7:0] l, input logic [7:0] i);
        ar_q.push_back('{addr: a, len: l, id: i});
    endtask

    task automatic send_ar(input logic [15:0] a, input logic [7:0] l, input logic [7:0] i);
        int n = 0;
        s_ar_valid = 1'b1;
        s_ar_addr  = a;
        s_ar_len   = l;
        s_ar_id    = i;
        @(negedge clk);
        while (!s_ar_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!s_ar_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_ar_timeout: got s_ar_ready=0, expected 1");
        end
        tick();
        s_ar_valid = 1'b0;
    endtask

    task automatic wait_ar_drain();
        int n = 0;
        while (ar_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (ar_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL ar_drain_timeout: got %0d pending, expected 0", ar_q.size());
        end
        tick();
    endtask

    task automatic r_beat(input logic [7:0] d, input logic [7:0] i, input logic last,
                          input logic exp_last);
        r_q.push_back('{data: d, id: i, last: exp_last});
        m_r_valid = 1'b1;
        m_r_data  = d;
        m_r_id    = i;
        m_r_last  = last;
        tick();
        m_r_valid = 1'b0;
        m_r_last  = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        s_ar_valid = 1'b0;
        s_ar_addr  = '0;
        s_ar_len   = '0;
        s_ar_id    = '0;
        m_ar_ready = 1'b1;
        m_r_valid  = 1'b0;
        m_r_data   = '0;
        m_r_id     = '0;
        m_r_last   = 1'b0;
        s_r_ready  = 1'b1;

        // Reset state
        tick();
        tick();
        @(negedge clk);
        chk("rst_s_ar_ready", 32'(s_ar_ready), 32'd0);
        chk("rst_m_ar_valid", 32'(m_ar_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("idle_s_ar_ready", 32'(s_ar_ready), 32'd1);
        chk("idle_busy", 32'(busy), 32'd0);
        tick();

        // Single beat
        exp_ar(16'h0eef, 8'd0, 8'd5);
        send_ar(16'h0eef, 8'd0, 8'd5);
        wait_ar_drain();
        @(negedge clk);
        chk("single_busy_before_r", 32'(busy), 32'd1);
        tick();
        r_beat(8'hA5, 8'd5, 1'b1, 1'b1);
        @(negedge clk);
        chk("single_busy_after_r", 32'(busy), 32'd0);
        tick();

        // Split 10 beats into 4+4+2
        exp_ar(16'h0100, 8'd3, 8'd3);
        exp_ar(16'h0104, 8'd3, 8'd3);
        exp_ar(16'h0108, 8'd1, 8'd3);
        send_ar(16'h0100, 8'd9, 8'd3);
        wait_ar_drain();
        for (int b = 1; b <= 10; b++) begin
            r_beat(8'(b), 8'd3, (b == 4 || b == 8 || b == 10), (b == 10));
        end

        // AR backpressure in SPLIT
        m_ar_ready = 1'b0;
        exp_ar(16'h0200, 8'd3, 8'd9);
        exp_ar(16'h0204, 8'd3, 8'd9);
        send_ar(16'h0200, 8'd7, 8'd9);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("bp_m_ar_valid", 32'(m_ar_valid), 32'd1);
            chk("bp_m_ar_addr", 32'(m_ar_addr), 32'h0200);
            chk("bp_m_ar_len", 32'(m_ar_len), 32'd3);
            chk("bp_s_ar_ready", 32'(s_ar_ready), 32'd0);
            tick();
        end
        m_ar_ready = 1'b1;
        wait_ar_drain();
        for (int b = 1; b <= 8; b++) begin
            r_beat(8'(8'h40 + b), 8'd9, (b == 4 || b == 8), (b == 8));
        end

        // Address wrap
        exp_ar(16'hfffe, 8'd3, 8'd1);
        exp_ar(16'h0002, 8'd1, 8'd1);
        send_ar(16'hfffe, 8'd5, 8'd1);
        wait_ar_drain();
        for (int b = 1; b <= 6; b++) begin
            r_beat(8'(8'h60 + b), 8'd1, (b == 4 || b == 6), (b == 6));
        end

        // Tracking FIFO full
        for (int k = 0; k < 4; k++) begin
            exp_ar(16'(16'h0010 + k), 8'd0, 8'(10 + k));
            send_ar(16'(16'h0010 + k), 8'd0, 8'(10 + k));
        end
        s_ar_valid = 1'b1;
        s_ar_addr  = 16'h0020;
        s_ar_len   = 8'd0;
        s_ar_id    = 8'd14;
        exp_ar(16'h0020, 8'd0, 8'd14);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("full_s_ar_ready", 32'(s_ar_ready), 32'd0);
            tick();
        end
        r_q.push_back('{data: 8'h80, id: 8'd10, last: 1'b1});
        m_r_valid = 1'b1;
        m_r_data  = 8'h80;
        m_r_id    = 8'd10;
        m_r_last  = 1'b1;
        @(negedge clk);
        chk("full_pop_same_cycle_ready", 32'(s_ar_ready), 32'd0);
        tick();
        m_r_valid = 1'b0;
        m_r_last  = 1'b0;
        @(negedge clk);
        chk("after_pop_s_ar_ready", 32'(s_ar_ready), 32'd1);
        tick();
        s_ar_valid = 1'b0;
        wait_ar_drain();
        for (int k = 1; k <= 4; k++) begin
            r_beat(8'(8'h80 + k), 8'(10 + k), 1'b1, 1'b1);
        end
        @(negedge clk);
        chk("drained_busy", 32'(busy), 32'd0);
        chk("no_err_yet", 32'(err), 32'd0);
        tick();

        // Stray R beat sets sticky err
        r_beat(8'h77, 8'd0, 1'b1, 1'b0);
        @(negedge clk);
        chk("err_set", 32'(err), 32'd1);
        tick();
        tick();
        @(negedge clk);
        chk("err_sticky", 32'(err), 32'd1);
        tick();

        // Reset mid-SPLIT
        m_ar_ready = 1'b0;
        send_ar(16'h0300, 8'd3, 8'd2);
        @(negedge clk);
        chk("split_m_ar_valid", 32'(m_ar_valid), 32'd1);
        chk("split_busy", 32'(busy), 32'd1);
        tick();
        rst = 1'b1;
        @(negedge clk);
        chk("in_rst_m_ar_valid", 32'(m_ar_valid), 32'd0);
        chk("in_rst_s_ar_ready", 32'(s_ar_ready), 32'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_m_ar_valid", 32'(m_ar_valid), 32'd0);
        chk("post_rst_busy", 32'(busy), 32'd0);
        chk("post_rst_err", 32'(err), 32'd0);
        chk("post_rst_s_ar_ready", 32'(s_ar_ready), 32'd1);
        m_ar_ready = 1'b1;
        tick();
        @(negedge clk);
        chk("post_rst_still_idle", 32'(m_ar_valid), 32'd0);
        tick();

        chk("ar_left_over", 32'(ar_q.size()), 32'd0);
        chk("r_left_over", 32'(r_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
